// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared timing constants and helpers for the button front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam int CLK_HZ              = 100000000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
    localparam int DEF_HOLD_CYCLES     = CLK_HZ;         // 1 s

    localparam int DBG_DEBOUNCE = 4;
    localparam int DBG_HOLD     = 16;

    // Counter width that never collapses to zero bits for tiny cycle counts.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_ch
//  Description : One button channel: 2-flop sync, debounce, edge and hold pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic btn,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int c_db_w   = cnt_width(DEBOUNCE_CYCLES);
    localparam int c_hold_w = cnt_width(HOLD_CYCLES + 1);
    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    logic                r_s1;
    logic                r_s2;
    logic                r_stable;
    logic [c_db_w-1:0]   r_db_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_fired;
    logic                r_press;
    logic                r_release;
    logic                r_hold;
    logic                w_accept;

    assign w_accept = (r_s2 != r_stable) && (r_db_cnt == c_db_last);

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_fired    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_s1      <= btn;
            r_s2      <= r_s1;
            // Pulses land on the same edge that updates the stable level.
            r_press   <= w_accept &  r_s2;
            r_release <= w_accept & ~r_s2;
            r_hold    <= 1'b0;

            if (r_s2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            if (!r_stable) begin
                r_hold_cnt <= '0;
                r_fired    <= 1'b0;
            end else if (!r_fired) begin
                if (r_hold_cnt == c_hold_last) begin
                    r_hold  <= 1'b1;
                    r_fired <= 1'b1;
                end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
        end
    end

    assign level_o   = r_stable;
    assign press_o   = r_press;
    assign release_o = r_release;
    assign hold_o    = r_hold;

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Debounced button bank plus stopwatch run/stop and clear strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int START_IDX       = 1,
    parameter int RESET_IDX       = 0
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] hold_o,
    output logic             run_o,
    output logic             clear_o
);

    if (START_IDX == RESET_IDX) begin : g_idx_clash
        $error("btn_conditioner: START_IDX and RESET_IDX must differ");
    end

    if (START_IDX >= N_BTN || RESET_IDX >= N_BTN) begin : g_idx_range
        $error("btn_conditioner: START_IDX/RESET_IDX out of range");
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .mclk      (mclk),
            .rst_n     (rst_n),
            .btn       (btn[gi]),
            .level_o   (level_o[gi]),
            .press_o   (press_o[gi]),
            .release_o (release_o[gi]),
            .hold_o    (hold_o[gi])
        );
    end

    logic r_run;
    logic r_clear;

    // Clear has priority over a simultaneous start/stop press.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_clear <= press_o[RESET_IDX];
            if (press_o[RESET_IDX]) begin
                r_run <= 1'b0;
            end else if (press_o[START_IDX]) begin
                r_run <= ~r_run;
            end
        end
    end

    assign run_o   = r_run;
    assign clear_o = r_clear;

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Directed vector table plus corner-case sequences for btn_conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;
    import btn_pkg::*;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic [1:0] btn;
    logic [1:0] level_o, press_o, release_o, hold_o;
    logic       run_o, clear_o;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    btn_conditioner #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (DBG_DEBOUNCE),
        .HOLD_CYCLES     (DBG_HOLD),
        .START_IDX       (1),
        .RESET_IDX       (0)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .btn       (btn),
        .level_o   (level_o),
        .press_o   (press_o),
        .release_o (release_o),
        .hold_o    (hold_o),
        .run_o     (run_o),
        .clear_o   (clear_o)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] btn;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [9:0] mk(input logic [1:0] l, input logic [1:0] p,
                                      input logic [1:0] r, input logic [1:0] h,
                                      input logic run, input logic clr);
        return {l, p, r, h, run, clr};
    endfunction

    function automatic logic [9:0] outs();
        return {level_o, press_o, release_o, hold_o, run_o, clear_o};
    endfunction

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one button to a clean new level and check the debounce latency.
    task automatic edge_seq(input int idx, input logic val);
        btn[idx] = val;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) begin
                chk("level_wait", 32'(level_o[idx]), 32'(!val));
            end else begin
                chk("level_new", 32'(level_o[idx]), 32'(val));
                chk("press_pulse", 32'(press_o[idx]), 32'(val));
                chk("release_pulse", 32'(release_o[idx]), 32'(!val));
            end
        end
    endtask

    task automatic setv(input int i, input logic r, input logic [1:0] b, input logic [9:0] e);
        vecs[i].rst_n = r;
        vecs[i].btn   = b;
        vecs[i].exp   = e;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 2'b11;

        // Reset with buttons held, then release: step seen on s1 at edge 3.
        setv(0,  1'b0, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(1,  1'b0, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(2,  1'b0, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(3,  1'b1, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(4,  1'b1, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(5,  1'b1, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(6,  1'b1, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(7,  1'b1, 2'b11, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(8,  1'b1, 2'b11, mk(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(9,  1'b1, 2'b11, mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
        setv(10, 1'b1, 2'b00, mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(11, 1'b1, 2'b00, mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(12, 1'b1, 2'b00, mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(13, 1'b1, 2'b00, mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(14, 1'b1, 2'b00, mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        setv(15, 1'b1, 2'b00, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        setv(16, 1'b1, 2'b00, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));

        for (int v = 0; v < 17; v++) begin
            rst_n = vecs[v].rst_n;
            btn   = vecs[v].btn;
            step();
            chk($sformatf("vec%0d", v), 32'(outs()), 32'(vecs[v].exp));
        end

        // Bounce on btn[1] every 2 cycles never survives the debounce window.
        for (int c = 0; c < 20; c++) begin
            btn[1] = ((c / 2) % 2) == 0;
            step();
            chk("bounce", 32'(outs()), 32'(0));
        end
        btn = 2'b00;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("bounce_tail", 32'(outs()), 32'(0));
        end

        // Clean start press toggles run, second press stops it.
        edge_seq(1, 1'b1);
        step();
        chk("run_on", 32'({press_o, run_o, clear_o}), 32'(3'b010));
        edge_seq(1, 1'b0);
        chk("run_kept", 32'(run_o), 32'(1));
        edge_seq(1, 1'b1);
        step();
        chk("run_off", 32'(run_o), 32'(0));
        edge_seq(1, 1'b0);

        // Long hold: exactly one pulse HOLD cycles after press.
        edge_seq(0, 1'b1);
        for (int j = 1; j <= 28; j++) begin
            step();
            if (j == 1) chk("hold_clear", 32'({run_o, clear_o}), 32'(2'b01));
            chk($sformatf("hold_j%0d", j), 32'(hold_o), 32'(j == 16 ? 2'b01 : 2'b00));
        end
        edge_seq(0, 1'b0);
        chk("hold_after_rel", 32'(hold_o), 32'(0));

        // Short hold released early: level high only 10 cycles, no hold pulse.
        btn[0] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            if (j == 6) chk("short_press", 32'(press_o[0]), 32'(1));
        end
        btn[0] = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            chk("short_nohold", 32'(hold_o), 32'(0));
        end

        // Clear beats a simultaneous start press.
        edge_seq(1, 1'b1);
        step();
        chk("prio_run_on", 32'(run_o), 32'(1));
        edge_seq(1, 1'b0);
        btn = 2'b11;
        for (int i = 1; i <= 5; i++) step();
        step();
        chk("prio_press", 32'(outs()), 32'(mk(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0)));
        step();
        chk("prio_clear", 32'(outs()), 32'(mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1)));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("prio_after", 32'({run_o, clear_o}), 32'(0));
        end
        btn = 2'b00;
        for (int i = 1; i <= 6; i++) step();
        chk("prio_release", 32'(outs()), 32'(mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0)));

        // Reset mid-count while running.
        edge_seq(1, 1'b1);
        step();
        chk("mid_run_on", 32'(run_o), 32'(1));
        btn[0] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        step();
        chk("mid_reset", 32'(outs()), 32'(0));
        btn   = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mid_quiet", 32'(outs()), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_conditioner
`default_nettype wire
